// File: rtl/fal6567_pkg.sv
// Shared definitions for the FAL6567 color fetch block.
//   NCOLS_DEFAULT : color entries fetched per badline
//   VC_W, IDX_W   : video counter width and line buffer index width
//   color_t       : one color byte
//   cfetch_state_e: fetch sequencer states
package fal6567_pkg;

  localparam int NCOLS_DEFAULT = 40;
  localparam int VC_W          = 10;
  localparam int IDX_W         = 6;

  typedef logic [7:0] color_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } cfetch_state_e;

endpackage

// File: rtl/fal6567_line_buf.sv
// Color line buffer: one synchronous write port, one registered read port.
//   clk, rst_n : clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata : write port
//   raddr      : read index; indices >= NCOLS read back as 8'h00
//   rdata      : registered read data (old value on a same-entry collision)
module fal6567_line_buf
  import fal6567_pkg::*;
#(
  parameter int NCOLS = NCOLS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  color_t           wdata,
  input  logic [IDX_W-1:0] raddr,
  output color_t           rdata
);

  color_t mem [2**IDX_W];

  // NOTE: the storage array is deliberately not reset; entries must survive
  // reset and carry over between rows until they are overwritten.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reading the array before the write above commits yields the old value
  // when both ports address the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (int'(raddr) < NCOLS) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/fal6567_color_fetch.sv
// FAL6567 color RAM fetch sequencer with line buffer.
// On an accepted badline it issues NCOLS color RAM addresses (one per ce
// cycle), captures the returned bytes two clocks after each issue into the
// line buffer, and serves the graphics sequencer through a registered read.
//   clk, rst_n     : clock, asynchronous active-low reset
//   badline        : start-fetch request (ignored while busy)
//   ce             : fetch slot enable
//   vcbase, cbank  : low / high color RAM address parts
//   ra             : registered color RAM address
//   cd             : color RAM data, valid one clk after ra is registered
//   vmli, co       : line buffer read index and registered color
//   busy, done     : fetch/drain in progress, last-entry-written pulse
// Build option: define FAL6567_CFETCH_NIBBLE_EN to keep only cd[3:0].
module fal6567_color_fetch
  import fal6567_pkg::*;
#(
  parameter int NCOLS = NCOLS_DEFAULT,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             badline,
  input  logic             ce,
  input  logic [VC_W-1:0]  vcbase,
  input  logic [AW-11:0]   cbank,
  output logic [AW-1:0]    ra,
  input  color_t           cd,
  input  logic [IDX_W-1:0] vmli,
  output color_t           co,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCOLS - 1);

  cfetch_state_e    state;
  logic [IDX_W-1:0] idx;
  // Two-stage tag pipeline: the RAM registers ra, then cd is captured.
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_last;
  color_t           wdata;

  assign wr_last = vld_d && (idx_d == LAST);

`ifdef FAL6567_CFETCH_NIBBLE_EN
  assign wdata = {4'h0, cd[3:0]};
`else
  assign wdata = cd;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, keeping the tag pipeline aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      ra    <= '0;
      vld_q <= 1'b0;
      vld_d <= 1'b0;
      idx_q <= '0;
      idx_d <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      vld_d <= vld_q;
      idx_d <= idx_q;
      done  <= wr_last;
      case (state)
        IDLE: begin
          if (badline) begin
            state <= FETCH;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (ce) begin
            ra    <= {cbank, vcbase + {{(VC_W-IDX_W){1'b0}}, idx}};
            idx   <= idx + 1'b1;
            vld_q <= 1'b1;
            idx_q <= idx;
            if (idx == LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          // badline in this clk is not looked at: state is still DRAIN.
          if (wr_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  fal6567_line_buf #(.NCOLS(NCOLS)) u_line_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (vld_d),
    .waddr (idx_d),
    .wdata (wdata),
    .raddr (vmli),
    .rdata (co)
  );

endmodule

// File: tb/tb_fal6567_color_fetch.sv
// Self-checking bench for fal6567_color_fetch: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a
// transaction-level model (issue queue with due times, array line buffer).
module tb_fal6567_color_fetch;
  import fal6567_pkg::*;

  localparam int NCOLS = 40;
  localparam int AW    = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        badline = 1'b0;
  logic        ce = 1'b0;
  logic [9:0]  vcbase = '0;
  logic [1:0]  cbank = '0;
  logic [11:0] ra;
  color_t      cd;
  logic [5:0]  vmli = '0;
  color_t      co;
  logic        busy, done;

  fal6567_color_fetch #(.NCOLS(NCOLS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .badline(badline), .ce(ce), .vcbase(vcbase),
    .cbank(cbank), .ra(ra), .cd(cd), .vmli(vmli), .co(co), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Color RAM: registers the address, data follows one clk later.
  logic [7:0]  cram [4096];
  logic [11:0] ram_q = '0;
  always @(posedge clk) ram_q <= ra;
  assign cd = cram[ram_q];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic color_t stored(input color_t v);
`ifdef FAL6567_CFETCH_NIBBLE_EN
    return {4'h0, v[3:0]};
`else
    return v;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int          n;
    logic [11:0] addr;
    longint      due;
  } pend_t;

  pend_t       pend[$];
  color_t      mbuf  [NCOLS];
  bit          known [NCOLS];
  longint      mcyc = 0;
  bit          m_busy = 0;
  int          m_n = 0;
  logic [11:0] m_ra = '0;
  color_t      m_co = '0;
  bit          m_co_known = 1;
  bit          m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_n = 0; m_ra = '0; m_co = '0; m_co_known = 1; m_done = 0;
      pend.delete();
    end else begin
      bit    start;
      pend_t e;
      mcyc++;
      if (int'(vmli) < NCOLS) begin
        m_co_known = known[vmli];
        m_co = mbuf[vmli];
      end else begin
        m_co_known = 1;
        m_co = '0;
      end
      m_done = 0;
      start = !m_busy && badline;
      if (m_busy && m_n < NCOLS && ce) begin
        e.n = m_n;
        e.addr = {cbank, 10'(int'(vcbase) + m_n)};
        e.due = mcyc + 2;
        m_ra = e.addr;
        pend.push_back(e);
        m_n++;
      end
      while (pend.size() > 0 && pend[0].due == mcyc) begin
        e = pend.pop_front();
        mbuf[e.n] = stored(cram[e.addr]);
        known[e.n] = 1;
        if (e.n == NCOLS - 1) begin
          m_done = 1;
          m_busy = 0;
        end
      end
      if (start) begin
        m_busy = 1;
        m_n = 0;
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_ra", 32'(ra), 32'(m_ra));
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
      if (m_co_known) check("model_co", 32'(co), 32'(m_co));
    end
  end

  // ---------------- directed helpers ----------------
  logic [11:0] ra_log [301];

  task automatic fetch_run(input int ce_mode, input int rebad_k,
                           output int done_k, output int done_cnt);
    done_k = -1;
    done_cnt = 0;
    for (int k = 0; k <= 300; k++) begin
      @(negedge clk);
      badline = (k == 0) || (k == rebad_k);
      case (ce_mode)
        0: ce = 1'b1;
        1: ce = (k % 2) == 1;
        default: ce = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      #1;
      ra_log[k] = ra;
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (done_cnt > 0 && !busy) break;
    end
    @(negedge clk);
    badline = 1'b0;
    ce = 1'b0;
    if (done_k < 0) check("fetch_timeout", 0, 1);
  endtask

  task automatic read_co(input int v, output color_t val);
    @(negedge clk);
    vmli = 6'(v);
    @(posedge clk);
    #1;
    val = co;
  endtask

  int     dk, dc;
  color_t rv;
  color_t nib_exp;

  initial begin
    for (int i = 0; i < 4096; i++) cram[i] = 8'(i);
    #1 rst_n = 1'b0;
    cmp_en = 1;
    @(negedge clk);
    check("reset_ra", 32'(ra), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_co", 32'(co), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic fetch, vcbase=0: ra 0..39, done at clk 42, buffer[i]=i.
    vcbase = 10'd0; cbank = 2'd0;
    fetch_run(0, -1, dk, dc);
    check("a_done_clk", 32'(dk), 42);
    check("a_done_cnt", 32'(dc), 1);
    check("a_ra1", 32'(ra_log[1]), 32'h000);
    check("a_ra20", 32'(ra_log[20]), 32'h013);
    check("a_ra40", 32'(ra_log[40]), 32'h027);
    read_co(0, rv);  check("a_buf0", 32'(rv), 32'(stored(8'h00)));
    read_co(17, rv); check("a_buf17", 32'(rv), 32'(stored(8'h11)));
    read_co(39, rv); check("a_buf39", 32'(rv), 32'(stored(8'h27)));

    // 10-bit wrap with cbank=3.
    vcbase = 10'd1000; cbank = 2'b11;
    fetch_run(0, -1, dk, dc);
    check("b_ra_first", 32'(ra_log[1]), 32'hFE8);
    check("b_ra_top", 32'(ra_log[24]), 32'hFFF);
    check("b_ra_wrap", 32'(ra_log[25]), 32'hC00);
    check("b_ra_last", 32'(ra_log[40]), 32'hC0F);
    read_co(0, rv);  check("b_buf0", 32'(rv), 32'(stored(8'hE8)));
    read_co(24, rv); check("b_buf24", 32'(rv), 32'(stored(8'h00)));

    // ce toggling 1,0: 40 issues over 80 clk.
    vcbase = 10'd0; cbank = 2'd0;
    fetch_run(1, -1, dk, dc);
    check("c_done_clk", 32'(dk), 81);
    check("c_done_cnt", 32'(dc), 1);
    check("c_ra79", 32'(ra_log[79]), 32'h027);
    check("c_ra80_hold", 32'(ra_log[80]), 32'h027);
    read_co(39, rv); check("c_buf39", 32'(rv), 32'(stored(8'h27)));

    // badline re-asserted at entry 20 is ignored.
    fetch_run(0, 21, dk, dc);
    check("d_done_cnt", 32'(dc), 1);
    check("d_done_clk", 32'(dk), 42);
    read_co(45, rv); check("d_vmli45", 32'(rv), 0);

    // badline in the DRAIN->IDLE clk does not start a fetch.
    fetch_run(0, 42, dk, dc);
    check("e_done_clk", 32'(dk), 42);
    @(posedge clk); #1;
    check("e_no_restart", 32'(busy), 0);

    // Reset at entry 10, then refetch from idx 0.
    vmli = 6'd39;
    vcbase = 10'd200; cbank = 2'd1;
    @(negedge clk); badline = 1'b1; ce = 1'b1;
    @(posedge clk);
    @(negedge clk); badline = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("r_busy", 32'(busy), 0);
    check("r_co", 32'(co), 0);
    check("r_ra", 32'(ra), 0);
    check("r_done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1; ce = 1'b0;
    vcbase = 10'd5;
    fetch_run(0, -1, dk, dc);
    check("r_refetch_ra1", 32'(ra_log[1]), 32'h405);
    check("r_refetch_done", 32'(dk), 42);

    // Nibble option.
    cram[{2'b01, 10'd100}] = 8'hA7;
    vcbase = 10'd100; cbank = 2'd1;
    fetch_run(0, -1, dk, dc);
`ifdef FAL6567_CFETCH_NIBBLE_EN
    nib_exp = 8'h07;
`else
    nib_exp = 8'hA7;
`endif
    read_co(0, rv); check("n_a7", 32'(rv), 32'(nib_exp));

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 4096; i++) cram[i] = 8'($urandom);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      badline = ($urandom_range(0, 39) == 0);
      ce = ($urandom_range(0, 3) != 0);
      vmli = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 99) == 0) vcbase = 10'($urandom);
      if ($urandom_range(0, 99) == 0) cbank = 2'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
